fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - three-cycle fetch/latch/execute sequencer with pc, instruction register and flags
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [12:0] rom_data,
  output logic [4:0]  opcode,
  output logic [7:0]  operand,
  input  logic        PC_LOAD,
  input  logic        PC_EN,
  input  logic        HALT,
  input  logic        ALU_EN,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        zeroF,
  output logic        carryF,
  output logic        exec_valid,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [7:0]  operand_q, operand_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        exec_q, halted_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        opcode_d  = rom_data[12:8];
        operand_d = rom_data[7:0];
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        // HALT wins over everything, including the flag update
        if (HALT) begin
          state_d = S_HALTED;
        end else begin
          if (PC_LOAD)    pc_d = operand_q;
          else if (PC_EN) pc_d = pc_q + 8'd1;
          if (ALU_EN) begin
            zero_d  = alu_zero;
            carry_d = alu_carry;
          end
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // exec_valid/halted are registered from the next-state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'h00;
      opcode_q  <= 5'b00000;
      operand_q <= 8'h00;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      exec_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      exec_q    <= (state_d == S_EXEC);
      halted_q  <= (state_d == S_HALTED);
    end
  end

  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign opcode     = opcode_q;
  assign operand    = operand_q;
  assign zeroF      = zero_q;
  assign carryF     = carry_q;
  assign exec_valid = exec_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer with an instruction-level reference model
module tb_fetch_sequencer;

  localparam logic [4:0] OP_NOP = 5'd0, OP_JMP = 5'd1, OP_HLT = 5'd2, OP_ADD = 5'd3,
                         OP_LDI = 5'd4, OP_JAF = 5'd5, OP_HAL = 5'd6, OP_STL = 5'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [12:0] rom_data = 13'd0;
  logic [4:0]  opcode;
  logic [7:0]  operand;
  logic        PC_LOAD, PC_EN, HALT, ALU_EN;
  logic        alu_zero = 1'b0, alu_carry = 1'b0;
  logic        zeroF, carryF, exec_valid, halted;
  logic [7:0]  pc;

  logic [12:0] rom [256];
  bit          seen [256];
  logic [3:0]  noise = 4'd0;
  int          total = 0, bad = 0, cyc = 0, last_exec = 0;
  int          mpc = 0;
  bit          mz = 0, mc = 0, mhalt = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .opcode(opcode), .operand(operand), .PC_LOAD(PC_LOAD), .PC_EN(PC_EN), .HALT(HALT),
    .ALU_EN(ALU_EN), .alu_zero(alu_zero), .alu_carry(alu_carry), .zeroF(zeroF),
    .carryF(carryF), .exec_valid(exec_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rom_data <= rom[rom_addr];
    if (rst_n) seen[rom_addr] = 1'b1;
  end

  // Control unit: {HALT, PC_LOAD, PC_EN, ALU_EN}; random junk outside EXEC
  function automatic logic [3:0] decode(input logic [4:0] op);
    case (op)
      OP_NOP:  return 4'b0010;
      OP_JMP:  return 4'b0100;
      OP_HLT:  return 4'b1000;
      OP_ADD:  return 4'b0011;
      OP_LDI:  return 4'b0010;
      OP_JAF:  return 4'b0111;
      OP_HAL:  return 4'b1111;
      OP_STL:  return 4'b0000;
      default: return 4'b0010;
    endcase
  endfunction

  assign {HALT, PC_LOAD, PC_EN, ALU_EN} = exec_valid ? decode(opcode) : noise;

  initial forever begin
    @(negedge clk);
    noise = 4'($urandom);
  end

  task automatic start_program();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mpc = 0; mz = 0; mc = 0; mhalt = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    run = 1'b1;
  endtask

  // Executes one instruction against the model; zf/cf < 0 means random ALU flags
  task automatic exec_one(input bit chk_gap, input int zf, input int cf, input string tag);
    int n;
    logic [4:0] op;
    logic [7:0] opd;
    n = 0;
    while (exec_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exec_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s exec_timeout: exec_valid=%b after %0d cycles, need 1", tag, exec_valid, n);
      return;
    end
    total++;
    if ({opcode, operand} !== rom[mpc[7:0]]) begin
      bad++;
      $display("FAIL %s ir: got %h, need %h (addr %h)", tag, {opcode, operand}, rom[mpc[7:0]], mpc[7:0]);
    end
    if (chk_gap) begin
      total++;
      if (cyc - last_exec != 3) begin
        bad++;
        $display("FAIL %s throughput: gap %0d cycles, need 3", tag, cyc - last_exec);
      end
    end
    last_exec = cyc;
    alu_zero  = (zf < 0) ? 1'($urandom) : 1'(zf);
    alu_carry = (cf < 0) ? 1'($urandom) : 1'(cf);
    op  = rom[mpc[7:0]][12:8];
    opd = rom[mpc[7:0]][7:0];
    if (op == OP_HLT || op == OP_HAL) begin
      mhalt = 1;
    end else begin
      if (op == OP_JMP || op == OP_JAF) mpc = opd;
      else if (op != OP_STL)            mpc = (mpc + 1) % 256;
      if (op == OP_ADD || op == OP_JAF) begin
        mz = alu_zero;
        mc = alu_carry;
      end
    end
    @(negedge clk);
    total++;
    if (pc !== mpc[7:0] || zeroF !== mz || carryF !== mc || halted !== mhalt || exec_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s post_exec: pc=%h z=%b c=%b h=%b ev=%b, need pc=%h z=%b c=%b h=%b ev=0",
               tag, pc, zeroF, carryF, halted, exec_valid, mpc[7:0], mz, mc, mhalt);
    end
  endtask

  task automatic check_frozen(input int n, input string tag);
    logic [20:0] snap;
    snap = {pc, opcode, operand, zeroF, carryF, halted};
    for (int i = 0; i < n; i++) begin
      run = 1'($urandom);
      alu_zero = 1'($urandom);
      alu_carry = 1'($urandom);
      @(negedge clk);
      total++;
      if ({pc, opcode, operand, zeroF, carryF, halted} !== snap || halted !== 1'b1 ||
          exec_valid !== 1'b0 || pc !== mpc[7:0]) begin
        bad++;
        $display("FAIL %s frozen[%0d]: pc=%h ir=%h%h h=%b ev=%b, need pc=%h halted=1 ev=0",
                 tag, i, pc, opcode, operand, halted, exec_valid, mpc[7:0]);
      end
    end
    run = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b1;
    #1;
    total++;
    if (pc !== 8'h00 || rom_addr !== 8'h00 || opcode !== 5'd0 || operand !== 8'h00 ||
        zeroF !== 1'b0 || carryF !== 1'b0 || exec_valid !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: pc=%h ir=%h%h z=%b c=%b ev=%b h=%b, need all zero",
               pc, opcode, operand, zeroF, carryF, exec_valid, halted);
    end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    repeat (5) @(negedge clk);
    total++;
    if (exec_valid !== 1'b0 || pc !== 8'h00) begin
      bad++;
      $display("FAIL idle_hold: ev=%b pc=%h, need ev=0 pc=00", exec_valid, pc);
    end
    run = 1'b1;
    n = 0;
    while (exec_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL start_latency: first exec after %0d cycles, need 3", n);
    end
  endtask

  task automatic test_nop_halt();
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    rom[2] = {OP_HLT, 8'h00};
    start_program();
    exec_one(0, -1, -1, "nophlt0");
    exec_one(1, -1, -1, "nophlt1");
    exec_one(1, -1, -1, "nophlt2");
    check_frozen(20, "nophlt");
  endtask

  task automatic test_jump();
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    rom[0] = {OP_JMP, 8'h05};
    rom[5] = {OP_HLT, 8'h00};
    start_program();
    exec_one(0, -1, -1, "jmp0");
    exec_one(1, -1, -1, "jmp1");
    check_frozen(5, "jmp");
    total++;
    if (seen[1] !== 1'b0) begin
      bad++;
      $display("FAIL jmp_skip: address 01 presented=%b, need 0", seen[1]);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    rom[0]   = {OP_JMP, 8'hFF};
    rom[255] = {OP_NOP, 8'hA5};
    start_program();
    exec_one(0, -1, -1, "wrap0");
    exec_one(1, -1, -1, "wrap1");
    total++;
    if (rom_addr !== 8'h00) begin
      bad++;
      $display("FAIL wrap_addr: rom_addr=%h, need 00", rom_addr);
    end
    exec_one(1, -1, -1, "wrap2");
  endtask

  task automatic test_flags();
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    rom[0] = {OP_ADD, 8'h11};
    rom[1] = {OP_LDI, 8'h22};
    rom[2] = {OP_HLT, 8'h00};
    start_program();
    exec_one(0, 1, 1, "flags_add");
    exec_one(1, 0, 0, "flags_ldi");
    total++;
    if (zeroF !== 1'b1 || carryF !== 1'b1) begin
      bad++;
      $display("FAIL flags_hold: z=%b c=%b, need 1 1", zeroF, carryF);
    end
    exec_one(1, 0, 0, "flags_hlt");
    check_frozen(4, "flags");
  endtask

  task automatic test_run_drop();
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    start_program();
    exec_one(0, -1, -1, "drop0");
    exec_one(1, -1, -1, "drop1");
    exec_one(1, -1, -1, "drop2");
    @(negedge clk);
    run = 1'b0;
    exec_one(1, -1, -1, "drop3");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (exec_valid !== 1'b0 || rom_addr !== 8'h04) begin
        bad++;
        $display("FAIL drop_idle[%0d]: ev=%b rom_addr=%h, need ev=0 addr=04", i, exec_valid, rom_addr);
      end
    end
    run = 1'b1;
    exec_one(0, -1, -1, "drop_resume");
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'(i)};
    rom[0] = {OP_ADD, 8'h00};
    rom[1] = {OP_JMP, 8'h10};
    start_program();
    exec_one(0, 1, 1, "rmid_add");
    n = 0;
    while (exec_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pc !== 8'h00 || zeroF !== 1'b0 || carryF !== 1'b0 || exec_valid !== 1'b0 || opcode !== 5'd0) begin
      bad++;
      $display("FAIL rmid_reset: pc=%h z=%b c=%b ev=%b op=%h, need 00 0 0 0 00",
               pc, zeroF, carryF, exec_valid, opcode);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 0; mz = 0; mc = 0; mhalt = 0;
    exec_one(0, -1, -1, "rmid_refetch");
    total++;
    if (seen[16] !== 1'b0) begin
      bad++;
      $display("FAIL rmid_nojump: address 10 presented=%b, need 0", seen[16]);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    bit resumed;
    int idle;
    for (int iter = 0; iter < 4; iter++) begin
      for (int i = 0; i < 256; i++) begin
        op = 5'($urandom_range(0, 9));
        if ((op == OP_HLT || op == OP_HAL) && $urandom_range(0, 5) != 0) op = OP_ADD;
        if (op == OP_STL && $urandom_range(0, 2) != 0) op = OP_NOP;
        rom[i] = {op, 8'($urandom)};
      end
      start_program();
      resumed = 1;
      for (int k = 0; k < 40 && !mhalt; k++) begin
        if (k > 0 && $urandom_range(0, 4) == 0) run = 1'b0;
        exec_one(!resumed, -1, -1, "rand");
        resumed = 0;
        if (!run && !mhalt) begin
          idle = $urandom_range(1, 6);
          repeat (idle) @(negedge clk);
          total++;
          if (exec_valid !== 1'b0 || pc !== mpc[7:0]) begin
            bad++;
            $display("FAIL rand_idle: ev=%b pc=%h, need ev=0 pc=%h", exec_valid, pc, mpc[7:0]);
          end
          run = 1'b1;
          resumed = 1;
        end
      end
      if (mhalt) check_frozen(6, "rand_halt");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 13'd0;
    test_reset();
    test_nop_halt();
    test_jump();
    test_wrap();
    test_flags();
    test_run_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
